// File: rtl/sck_control_master_if.sv
// Bus bundle between an SPI master SCK generator and its data path.
// master: the SCK generator itself. slave: whoever drives the controls and
// consumes the strobes.
interface sck_control_master_if #(
  parameter int DIV_WIDTH = 8
);
  logic                 start;
  logic                 CPOL;
  logic                 CPHA;
  logic [DIV_WIDTH-1:0] baud_div;
  logic                 SCK_out;
  logic                 Shift_en;
  logic                 Sample_en;
  logic                 busy;
  logic                 idle;
  logic                 done;

  modport master (
    input  start, CPOL, CPHA, baud_div,
    output SCK_out, Shift_en, Sample_en, busy, idle, done
  );

  modport slave (
    output start, CPOL, CPHA, baud_div,
    input  SCK_out, Shift_en, Sample_en, busy, idle, done
  );
endinterface

// File: rtl/sck_control_master.sv
// SPI master SCK generator. A control FSM paces half-periods and counts SCK
// edges; a second register stage turns each counted edge into the SCK toggle
// and its shift/sample strobe, so every output is a plain flop.
module sck_control_master #(
  parameter int DIV_WIDTH = 8,
  parameter int BITS      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  sck_control_master_if.master  bus
);
  localparam int NEDGE = 2 * BITS;
  localparam int KW    = $clog2(NEDGE + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, TRAIL} state_e;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [KW-1:0]        k_q, k_d;
  logic                 cpol_q, cpol_d;
  logic                 cpha_q, cpha_d;
  logic                 ev_q, ev_d;     // an SCK edge was counted last cycle
  logic                 fin_q, fin_d;   // trailing hold just ended
  logic                 sck_q, sck_d;
  logic                 shf_q, shf_d;
  logic                 smp_q, smp_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 hp_end;
  logic                 smp_edge;
  logic                 no_shift;

  // The counter never passes div_q, so an all-ones divider cannot wrap.
  assign hp_end = (cnt_q == div_q);

  // Control FSM: latch frame settings, pace half-periods, count edges.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    k_d     = k_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    ev_d    = 1'b0;
    fin_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ACTIVE;
          div_d   = bus.baud_div;
          cpol_d  = bus.CPOL;
          cpha_d  = bus.CPHA;
          cnt_d   = '0;
          k_d     = '0;
        end
      end
      ACTIVE: begin
        if (hp_end) begin
          cnt_d = '0;
          k_d   = k_q + 1'b1;
          ev_d  = 1'b1;
          if (k_q == KW'(NEDGE - 1)) state_d = TRAIL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TRAIL: begin
        if (hp_end) begin
          cnt_d   = '0;
          fin_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output stage: toggle SCK and classify the edge that was just counted.
  // While not busy SCK follows CPOL; in the first frame cycle busy has not
  // risen yet, so the latched polarity is used instead of the live pin.
  always_comb begin
    smp_edge = k_q[0] ^ cpha_q;
    no_shift = ((k_q == KW'(NEDGE)) && !cpha_q) || ((k_q == KW'(1)) && cpha_q);
    sck_d    = sck_q;
    smp_d    = 1'b0;
    shf_d    = 1'b0;
    if (ev_q) begin
      sck_d = ~sck_q;
      smp_d = smp_edge;
      shf_d = ~smp_edge & ~no_shift;
    end else if (!busy_q) begin
      sck_d = (state_q == IDLE) ? bus.CPOL : cpol_q;
    end
    busy_d = (state_q != IDLE);
    done_d = fin_q;
  end

  // State and output registers; reset aborts any frame on the spot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      k_q     <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      ev_q    <= 1'b0;
      fin_q   <= 1'b0;
      sck_q   <= bus.CPOL;
      shf_q   <= 1'b0;
      smp_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      k_q     <= k_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      ev_q    <= ev_d;
      fin_q   <= fin_d;
      sck_q   <= sck_d;
      shf_q   <= shf_d;
      smp_q   <= smp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.SCK_out   = sck_q;
  assign bus.Shift_en  = shf_q;
  assign bus.Sample_en = smp_q;
  assign bus.busy      = busy_q;
  assign bus.idle      = ~busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_sck_control_master.sv
// Bench for sck_control_master: a frame-vector table, hand sequences for the
// multi-cycle corners, and a randomized run, all continuously compared against
// a timing-formula reference model.
module tb_sck_control_master;
  localparam int DW = 8;
  localparam int B  = 8;
  localparam int NE = 2 * B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sck_control_master_if #(.DIV_WIDTH(DW)) bus();
  sck_control_master #(.DIV_WIDTH(DW), .BITS(B)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference model: a frame started at edge t0 with divider D has
  // h = D+1, edge k visible at t0 + k*h + 1, busy for m in 1..(NE+1)*h,
  // done at m = (NE+1)*h + 1. Outside a frame SCK follows live CPOL.
  int   cyc = 0;
  logic chk_en = 1'b0;
  logic m_in = 1'b0;
  int   m_t0 = 0, m_d = 0;
  logic m_pol = 1'b0, m_pha = 1'b0;
  logic e_sck, e_shf, e_smp, e_busy, e_done;

  always @(posedge clk) begin
    int m, h, kk, end_t;
    cyc++;
    e_sck = bus.CPOL; e_shf = 1'b0; e_smp = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    h = m_d + 1;
    end_t = (NE + 1) * h;
    m = cyc - m_t0;
    if (rst) begin
      m_in = 1'b0;
      chk_en = 1'b1;
    end else begin
      if (m_in && m > end_t + 1) m_in = 1'b0;
      if (m_in) begin
        kk = (m - 1) / h;
        e_busy = (m <= end_t);
        e_done = (m == end_t + 1);
        e_sck  = m_pol ^ (((kk > NE ? NE : kk) % 2) == 1);
        if (((m - 1) % h) == 0 && kk >= 1 && kk <= NE) begin
          if (((kk % 2) == 1) ^ m_pha) e_smp = 1'b1;
          else if (!((kk == NE && !m_pha) || (kk == 1 && m_pha))) e_shf = 1'b1;
        end
      end
      if (bus.start && (!m_in || m >= end_t + 1)) begin
        m_in  = 1'b1;
        m_t0  = cyc;
        m_d   = int'(bus.baud_div);
        m_pol = bus.CPOL;
        m_pha = bus.CPHA;
      end
    end
  end

  always @(negedge clk)
    if (chk_en)
      check("cycle", {bus.SCK_out, bus.Shift_en, bus.Sample_en, bus.busy, bus.idle, bus.done},
            {e_sck, e_shf, e_smp, e_busy, ~e_busy, e_done});

  typedef struct {
    logic pol;
    logic pha;
    int   d;
    int   t_tog;
    int   t_done;
    int   n_busy;
    int   n_smp;
    int   n_shf;
  } vec_t;

  task automatic run_frame(input logic pol, input logic pha, input int d,
                           output int t_tog, output int t_done, output int n_busy,
                           output int n_smp, output int n_shf);
    logic s0;
    t_tog = -1; t_done = -1; n_busy = 0; n_smp = 0; n_shf = 0;
    @(negedge clk);
    bus.CPOL = pol; bus.CPHA = pha; bus.baud_div = d[DW-1:0]; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    s0 = bus.SCK_out;
    for (int m = 1; m < 6000; m++) begin
      @(negedge clk);
      if (bus.busy) n_busy++;
      if (bus.Sample_en) n_smp++;
      if (bus.Shift_en) n_shf++;
      if (t_tog < 0 && bus.SCK_out !== s0) t_tog = m;
      if (bus.done) begin
        t_done = m;
        break;
      end
    end
  endtask

  initial begin
    vec_t tbl[5];
    int tt, td, tb, ts, tf, cnt, nd, ns, bad;
    tbl[0] = '{1'b0, 1'b0,   0,   2,   18,   17, 8, 7};
    tbl[1] = '{1'b1, 1'b1,   3,   5,   69,   68, 8, 7};
    tbl[2] = '{1'b0, 1'b1,   1,   3,   35,   34, 8, 7};
    tbl[3] = '{1'b1, 1'b0,   2,   4,   52,   51, 8, 7};
    tbl[4] = '{1'b0, 1'b0, 255, 257, 4353, 4352, 8, 7};

    bus.start = 1'b0; bus.CPOL = 1'b1; bus.CPHA = 1'b0; bus.baud_div = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sck_cpol1", bus.SCK_out, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_idle", bus.idle, 1);
    check("rst_done", bus.done, 0);
    check("rst_strobes", {bus.Shift_en, bus.Sample_en}, 0);
    bus.CPOL = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Frame vector table
    for (int i = 0; i < 5; i++) begin
      run_frame(tbl[i].pol, tbl[i].pha, tbl[i].d, tt, td, tb, ts, tf);
      check($sformatf("v%0d_first_toggle", i), tt, tbl[i].t_tog);
      check($sformatf("v%0d_done_time", i), td, tbl[i].t_done);
      check($sformatf("v%0d_busy_cycles", i), tb, tbl[i].n_busy);
      check($sformatf("v%0d_samples", i), ts, tbl[i].n_smp);
      check($sformatf("v%0d_shifts", i), tf, tbl[i].n_shf);
      repeat (3) @(negedge clk);
    end

    // Settings and start changes while busy have no effect on the frame
    @(negedge clk);
    bus.CPOL = 1'b0; bus.CPHA = 1'b0; bus.baud_div = 8'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.CPOL = 1'b1; bus.CPHA = 1'b1; bus.baud_div = 8'd7; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    td = -1;
    for (int m = 7; m < 200; m++) begin
      @(negedge clk);
      if (bus.done) begin
        td = m;
        break;
      end
    end
    check("latch_done_time", td, 35);
    check("latch_sck_in_done", bus.SCK_out, 0);
    @(negedge clk);
    check("latch_sck_new_cpol", bus.SCK_out, 1);
    cnt = 0;
    repeat (30) @(negedge clk) if (bus.busy) cnt++;
    check("latch_no_second_frame", cnt, 0);
    bus.CPOL = 1'b0; bus.CPHA = 1'b0; bus.baud_div = '0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a frame
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_sck", bus.SCK_out, 0);
    check("midrst_busy", bus.busy, 0);
    cnt = 0;
    repeat (40) @(negedge clk) if (bus.done || bus.Sample_en || bus.Shift_en) cnt++;
    check("midrst_quiet", cnt, 0);
    run_frame(1'b0, 1'b0, 0, tt, td, tb, ts, tf);
    check("midrst_next_done", td, 18);
    check("midrst_next_samples", ts, 8);
    repeat (3) @(negedge clk);

    // Back-to-back frames with start held high
    @(negedge clk);
    bus.CPOL = 1'b0; bus.CPHA = 1'b1; bus.baud_div = '0; bus.start = 1'b1;
    nd = 0; ns = 0; bad = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.Sample_en) ns++;
      if (bus.done) begin
        nd++;
        check("b2b_samples", ns, 8);
        ns = 0;
      end
      if (c >= 1 && bus.idle !== bus.done) bad++;
    end
    bus.start = 1'b0;
    check("b2b_idle_only_in_done", bad, 0);
    check("b2b_frames", nd, 3);
    repeat (40) @(negedge clk);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) begin
        bus.CPOL     = 1'($urandom_range(0, 1));
        bus.CPHA     = 1'($urandom_range(0, 1));
        bus.baud_div = DW'($urandom_range(0, 4));
      end
      rst = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b0;
    repeat (100) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
